// File: rtl/regfile_scoreboard_pkg.sv
// Shared pipeline constants and instruction field layouts
// used by decode, the register file and writeback.
package regfile_scoreboard_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = $clog2(NREG);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic [6:0] funct7;
    reg_idx_t   rs2;
    reg_idx_t   rs1;
    logic [2:0] funct3;
    reg_idx_t   rd;
    logic [6:0] opcode;
  } rtype_t;

endpackage

// File: rtl/regfile_bypass_port.sv
// One operand read port: x0 / writeback bypass / array mux
// plus the busy hazard term for that source.
module regfile_bypass_port
  import regfile_scoreboard_pkg::*;
#(
  parameter int W  = XLEN,
  parameter int N  = NREG,
  parameter int IW = $clog2(N)
) (
  input  logic [IW-1:0] num_i,
  input  logic          valid_i,
  input  logic [W-1:0]  regs_i [N],
  input  logic [N-1:0]  busy_i,
  input  logic          wbvalid_i,
  input  logic [IW-1:0] wbnum_i,
  input  logic [W-1:0]  wbdata_i,
  output logic [W-1:0]  data_o,
  output logic          haz_o
);

  logic w_zero;
  logic w_hit;
  logic w_byp;

  assign w_zero = (num_i == '0);
  assign w_hit  = wbvalid_i && (wbnum_i == num_i);
  // x0 beats the bypass so the two selects stay one-hot
  assign w_byp  = w_hit && !w_zero;

  always_comb begin
    data_o = '0;
    unique case (1'b1)
      w_zero:  data_o = '0;
      w_byp:   data_o = wbdata_i;
      default: data_o = regs_i[num_i];
    endcase
  end

  assign haz_o = valid_i && !w_zero &&
                 busy_i[num_i] && !w_hit;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register busy scoreboard,
// two bypassed read ports and a single writeback port.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN = regfile_scoreboard_pkg::XLEN,
  parameter int NREG = regfile_scoreboard_pkg::NREG,
  localparam int IW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   r0num_i,
  input  logic            r0valid_i,
  input  logic [IW-1:0]   r1num_i,
  input  logic            r1valid_i,
  input  logic [IW-1:0]   rdnum_i,
  input  logic            rdreserve_i,
  output logic [XLEN-1:0] r0data_o,
  output logic [XLEN-1:0] r1data_o,
  output logic            rsreserved_o,
  input  logic            wbvalid_i,
  input  logic [IW-1:0]   wbnum_i,
  input  logic [XLEN-1:0] wbdata_i,
  output logic [NREG-1:0] busy_o
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic            w_haz0;
  logic            w_haz1;
  logic            w_wb;
  logic            w_rsv;

  assign w_wb  = wbvalid_i && (wbnum_i != '0);
  assign w_rsv = rdreserve_i && (rdnum_i != '0);

  regfile_bypass_port #(
    .W  (XLEN),
    .N  (NREG),
    .IW (IW)
  ) u_port0 (
    .num_i     (r0num_i),
    .valid_i   (r0valid_i),
    .regs_i    (r_regs),
    .busy_i    (r_busy),
    .wbvalid_i (wbvalid_i),
    .wbnum_i   (wbnum_i),
    .wbdata_i  (wbdata_i),
    .data_o    (r0data_o),
    .haz_o     (w_haz0)
  );

  regfile_bypass_port #(
    .W  (XLEN),
    .N  (NREG),
    .IW (IW)
  ) u_port1 (
    .num_i     (r1num_i),
    .valid_i   (r1valid_i),
    .regs_i    (r_regs),
    .busy_i    (r_busy),
    .wbvalid_i (wbvalid_i),
    .wbnum_i   (wbnum_i),
    .wbdata_i  (wbdata_i),
    .data_o    (r1data_o),
    .haz_o     (w_haz1)
  );

  // Kept free of rdnum/rdreserve: decode closes the loop
  assign rsreserved_o = w_haz0 | w_haz1;
  assign busy_o       = r_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wb) begin
        r_regs[wbnum_i] <= wbdata_i;
        r_busy[wbnum_i] <= 1'b0;
      end
      // Younger producer's reservation overrides the clear
      if (w_rsv) begin
        r_busy[rdnum_i] <= 1'b1;
      end
    end
  end

endmodule
